cmd_uart_wrapper: RTL and testbench
===================================

Name: cmd_uart_wrapper

Overview:
Robot-side endpoint of the remote command link; the other end of the 16-bit-command/8-bit-response protocol that the host-side remote controller initiates.
- Receives two UART bytes (high byte first) and assembles them into a 16-bit command for the command processor.
- Serializes a one-byte response (e.g. positive ack 8'hA5) back to the host.
- Contains its own bit-level UART receiver and transmitter.

Parameters:
BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); legal 16..65535
TIMEOUT_CLKS, 1000000, clocks allowed between high and low byte (used only with CMD_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  serial in from host (idle high, asynchronous to clk)
TX  output  1  serial out to host (idle high)
cmd  output  16  assembled command {high_byte, low_byte}
cmd_rdy  output  1  set when a full command is assembled; held until cleared
clr_cmd_rdy  input  1  single-cycle pulse from consumer; clears cmd_rdy
resp  input  8  response byte to transmit
send_resp  input  1  single-cycle pulse; start transmitting resp
resp_sent  output  1  set when the response stop bit completes; cleared by next send_resp
tx_busy  output  1  high while a response frame is in flight

Behaviour:
Reset (async, rst_n low):
- TX=1, cmd=0, cmd_rdy=0, resp_sent=0, tx_busy=0.
- All FSMs go to IDLE/HIGH; RX synchronizer flops preset to 1.

RX path:
- RX passes through a two-flop synchronizer.
- Start is detected on a synced 1->0 edge in RX IDLE.
- Baud counter loads BAUD_DIV/2. At that count the start bit is re-sampled: if it reads 1, the event is a glitch and the receiver returns to IDLE.
- Otherwise 8 data bits are sampled LSB first, each BAUD_DIV clocks apart at mid-bit, then the stop bit.
- Stop bit = 0 is a framing error: the byte is discarded, the assembly FSM is unaffected, and the receiver returns to IDLE.
- Valid byte: a one-cycle internal rx_rdy strobe is produced in the cycle after the stop-bit sample.
- RX states: IDLE, START, DATA, STOP.

Assembly FSM (states HIGH, LOW):
- HIGH + rx_rdy: latch byte into high register, go to LOW.
- LOW + rx_rdy: cmd <= {high, byte}, cmd_rdy <= 1 on the next clk edge, go to HIGH.
- cmd updates only on command completion; it is stable while cmd_rdy is high unless a new command completes.
- New command completing while cmd_rdy=1: cmd overwritten, cmd_rdy stays 1.
- clr_cmd_rdy in the same cycle as completion: completion wins, cmd_rdy=1.
- clr_cmd_rdy with cmd_rdy=0: no effect.

TX path (states IDLE, XMIT):
- send_resp in IDLE: latch resp and frame it as {1 stop, resp[7:0], 0 start}, shifted LSB first.
- tx_busy=1 and resp_sent=0 from the next cycle.
- Each bit is held exactly BAUD_DIV clocks; frame length is 10*BAUD_DIV clocks.
- After the stop bit: tx_busy=0, resp_sent=1, TX=1.
- send_resp while tx_busy=1 is ignored; the frame in flight is not disturbed.
- RX and TX operate fully independently (full duplex).

Reset mid-operation: everything returns to reset values immediately. A partial frame is lost and TX returns high at once.

Optional Feature:
Macro: CMD_TIMEOUT_EN
- Defined:
  - A counter starts when the assembly FSM enters LOW and clears on every rx_rdy.
  - If it reaches TIMEOUT_CLKS before the low byte arrives, the FSM returns to HIGH and the stored high byte is discarded.
  - A one-cycle cmd_timeout output pulse is generated. This is an extra port, present only with the macro.
- Not defined:
  - No counter and no cmd_timeout port.
  - LOW waits indefinitely.

Test Plan:
- Host sends 0x47 then 0xF3 -> cmd=16'h47F3 and cmd_rdy=1 exactly one clk after the second byte's rx_rdy strobe; cmd_rdy holds until clr_cmd_rdy, then is 0 on the next clk.
- send_resp with resp=8'hA5 -> TX waveform is 0,1,0,1,0,0,1,0,1,1, each bit BAUD_DIV clks; resp_sent=1 after 10*BAUD_DIV clks; a second send_resp at mid-frame leaves the waveform unchanged.
- Byte 0x12 sent with stop bit forced 0, then 0x34, 0x56 -> first byte dropped; cmd=16'h3456 and cmd_rdy=1.
- RX low pulse of BAUD_DIV/4 clks (glitch), then 0xAB, 0xCD -> glitch ignored; cmd=16'hABCD.
- cmd_rdy=1 with cmd=16'h1111; new command 16'h2222 completes in the same cycle clr_cmd_rdy pulses -> cmd=16'h2222, cmd_rdy=1.
- CMD_TIMEOUT_EN defined with TIMEOUT_CLKS=5000: send 0x47, idle 6000 clks, then 0x10, 0x00 -> cmd_timeout pulses once; cmd=16'h1000, not 16'h4710.

Source files
------------

// File: rtl/cmd_uart_wrapper.sv
// cmd_uart_wrapper: robot-side endpoint of the remote command link.
// Receives two UART bytes (high byte first) and presents them as one 16-bit
// command. Transmits a one-byte response back to the host. RX and TX are
// independent, so the link is full duplex.
//
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   RX           - serial in from host (idle high, asynchronous)
//   TX           - serial out to host (idle high)
//   cmd          - assembled command {high_byte, low_byte}
//   cmd_rdy      - set on command completion, held until clr_cmd_rdy
//   clr_cmd_rdy  - single-cycle clear of cmd_rdy
//   resp         - response byte to transmit
//   send_resp    - single-cycle start of a response frame
//   resp_sent    - set when the stop bit completes, cleared by next send_resp
//   tx_busy      - high while a response frame is in flight
//   cmd_timeout  - one-cycle pulse when the low byte times out
//                  (present only when CMD_TIMEOUT_EN is defined)
//
// Optional feature macro: CMD_TIMEOUT_EN (abandon a half-received command
// after TIMEOUT_CLKS clocks in LOW).
module cmd_uart_wrapper #(
  parameter int unsigned BAUD_DIV     = 2604,
  parameter int unsigned TIMEOUT_CLKS = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
`ifdef CMD_TIMEOUT_EN
  ,
  output logic        cmd_timeout
`endif
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned HALF  = BAUD_DIV / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic       {ASM_HIGH, ASM_LOW} asm_state_e;
  typedef enum logic       {TX_IDLE, TX_XMIT} tx_state_e;

  // RX synchronizer and edge history (preset to idle level)
  logic rx_ff1_q, rx_ff2_q, rx_prev_q;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bits_q, rx_bits_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_rdy_q, rx_rdy_d;

  asm_state_e  asm_q, asm_d;
  logic [7:0]  high_q, high_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        low_expired_c;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bits_q, tx_bits_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;
  logic             tx_busy_q, tx_busy_d;
  logic             resp_sent_q, resp_sent_d;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1_q    <= 1'b1;
      rx_ff2_q    <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bits_q   <= '0;
      rx_shift_q  <= '0;
      rx_rdy_q    <= 1'b0;
      asm_q       <= ASM_HIGH;
      high_q      <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bits_q   <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      rx_ff1_q    <= RX;
      rx_ff2_q    <= rx_ff1_q;
      rx_prev_q   <= rx_ff2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bits_q   <= rx_bits_d;
      rx_shift_q  <= rx_shift_d;
      rx_rdy_q    <= rx_rdy_d;
      asm_q       <= asm_d;
      high_q      <= high_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bits_q   <= tx_bits_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  // Bit-level receiver: mid-bit sampling, glitch and framing rejection
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bits_d  = rx_bits_q;
    rx_shift_d = rx_shift_q;
    rx_rdy_d   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_ff2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = CNT_W'(HALF - 1);
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          // Line back high at mid-start means the falling edge was a glitch
          rx_state_d = rx_ff2_q ? RX_IDLE : RX_DATA;
          rx_cnt_d   = CNT_W'(BAUD_DIV - 1);
          rx_bits_d  = '0;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_ff2_q, rx_shift_q[7:1]};
          rx_cnt_d   = CNT_W'(BAUD_DIV - 1);
          rx_bits_d  = rx_bits_q + 3'd1;
          if (rx_bits_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          rx_rdy_d   = rx_ff2_q;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             cmd_timeout_q;

  // Counts clocks spent in LOW; any received byte restarts it
  always_comb begin
    tmo_cnt_d = '0;
    if (asm_q == ASM_LOW && !rx_rdy_q) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  assign low_expired_c = (asm_q == ASM_LOW) && !rx_rdy_q &&
                         (tmo_cnt_q == TMO_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      cmd_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= low_expired_c ? '0 : tmo_cnt_d;
      cmd_timeout_q <= low_expired_c;
    end
  end

  assign cmd_timeout = cmd_timeout_q;
`else
  // LOW waits indefinitely for the low byte
  assign low_expired_c = 1'b0;
`endif

  // Command assembly: completion has priority over clr_cmd_rdy
  always_comb begin
    asm_d     = asm_q;
    high_d    = high_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    unique case (asm_q)
      ASM_HIGH: begin
        if (rx_rdy_q) begin
          high_d = rx_shift_q;
          asm_d  = ASM_LOW;
        end
      end
      ASM_LOW: begin
        if (rx_rdy_q) begin
          cmd_d     = {high_q, rx_shift_q};
          cmd_rdy_d = 1'b1;
          asm_d     = ASM_HIGH;
        end else if (low_expired_c) begin
          asm_d = ASM_HIGH;
        end
      end
      default: asm_d = ASM_HIGH;
    endcase
  end

  // Transmitter: start bit driven directly, then data LSB first and stop
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bits_d   = tx_bits_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    tx_busy_d   = tx_busy_q;
    resp_sent_d = resp_sent_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_state_d  = TX_XMIT;
          tx_shift_d  = {1'b1, resp};
          tx_d        = 1'b0;
          tx_busy_d   = 1'b1;
          resp_sent_d = 1'b0;
          tx_cnt_d    = CNT_W'(BAUD_DIV - 1);
          tx_bits_d   = '0;
        end
      end
      TX_XMIT: begin
        if (tx_cnt_q == '0) begin
          if (tx_bits_q == 4'd9) begin
            tx_state_d  = TX_IDLE;
            tx_d        = 1'b1;
            tx_busy_d   = 1'b0;
            resp_sent_d = 1'b1;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bits_d  = tx_bits_q + 4'd1;
            tx_cnt_d   = CNT_W'(BAUD_DIV - 1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;
  assign tx_busy   = tx_busy_q;

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Testbench for cmd_uart_wrapper: drives UART bytes on RX, checks assembled
// commands against a byte-pairing model, and checks TX frames bit by bit.
module tb_cmd_uart_wrapper;

  localparam int B = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;
`ifdef CMD_TIMEOUT_EN
  logic        cmd_timeout;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: a stream of good bytes pairs into commands
  bit          m_have_high = 0;
  logic [7:0]  m_high = 8'h00;
  logic [15:0] m_cmd = 16'h0000;

  int cyc = 0;
  int rise_cyc = 0;
  int falls = 0;
  int last_start_cyc = 0;
  int tmo_pulses = 0;
  logic rdy_prev = 1'b0;

  always #5 clk = ~clk;

  cmd_uart_wrapper #(
    .BAUD_DIV(B)
`ifdef CMD_TIMEOUT_EN
    , .TIMEOUT_CLKS(5000)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .RX(rx),
    .TX(tx),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr),
    .resp(resp),
    .send_resp(send_resp),
    .resp_sent(resp_sent),
    .tx_busy(tx_busy)
`ifdef CMD_TIMEOUT_EN
    , .cmd_timeout(cmd_timeout)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (cmd_rdy && !rdy_prev) rise_cyc = cyc;
    if (!cmd_rdy && rdy_prev) falls = falls + 1;
    rdy_prev = cmd_rdy;
`ifdef CMD_TIMEOUT_EN
    if (cmd_timeout === 1'b1) tmo_pulses = tmo_pulses + 1;
`endif
  end

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_have_high = 0;
    m_cmd = 16'h0000;
  endtask

  // Send one UART frame; stop_ok=0 forces a framing error
  task automatic uart_send(input logic [7:0] b, input bit stop_ok);
    logic [9:0] frame;
    frame = {stop_ok ? 1'b1 : 1'b0, b, 1'b0};
    last_start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      wait_clks(B);
    end
    rx = 1'b1;
    wait_clks(4);
    if (stop_ok) begin
      if (!m_have_high) begin
        m_high = b;
        m_have_high = 1;
      end else begin
        m_cmd = {m_high, b};
        m_have_high = 0;
      end
    end
  endtask

  // One response frame checked at every mid-bit; optional mid-frame resend
  task automatic tx_frame_check(input logic [7:0] r, input bit disturb);
    logic [9:0] frame;
    frame = {1'b1, r, 1'b0};
    resp = r;
    send_resp = 1'b1;
    wait_clks(1);
    send_resp = 1'b0;
    for (int k = 0; k < 10 * B; k++) begin
      if (k % B == B / 2) begin
        total++;
        if (tx !== frame[k / B]) begin
          bad++;
          $display("FAIL tx_bit%0d resp=%h got=%b exp=%b", k / B, r, tx, frame[k / B]);
        end
      end
      if (k == 10 * B - 1) begin
        total++;
        if (tx_busy !== 1'b1 || resp_sent !== 1'b0) begin
          bad++;
          $display("FAIL tx_last_clk busy=%b sent=%b exp busy=1 sent=0", tx_busy, resp_sent);
        end
      end
      send_resp = (disturb && k == 5 * B + 3);
      if (send_resp) resp = ~r;
      wait_clks(1);
    end
    send_resp = 1'b0;
    total++;
    if (resp_sent !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL tx_done sent=%b busy=%b tx=%b exp 1,0,1", resp_sent, tx_busy, tx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    wait_clks(3);
    total++;
    if (tx !== 1'b1 || cmd !== 16'h0 || cmd_rdy !== 1'b0 || resp_sent !== 1'b0 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset tx=%b cmd=%h rdy=%b sent=%b busy=%b exp 1,0000,0,0,0",
               tx, cmd, cmd_rdy, resp_sent, tx_busy);
    end
    rst_n = 1'b1;
    wait_clks(3);
  endtask

  task automatic test_cmd();
    int lat;
    uart_send(8'h47, 1);
    uart_send(8'hF3, 1);
    lat = rise_cyc - last_start_cyc;
    total++;
    if (cmd !== 16'h47F3 || cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL cmd_basic cmd=%h rdy=%b exp 47F3,1", cmd, cmd_rdy);
    end
    total++;
    if (lat < 9 * B + B / 2 || lat > 9 * B + B / 2 + 8) begin
      bad++;
      $display("FAIL cmd_latency got=%0d exp %0d..%0d", lat, 9 * B + B / 2, 9 * B + B / 2 + 8);
    end
    wait_clks(20);
    total++;
    if (cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL cmd_rdy_hold got=%b exp 1", cmd_rdy);
    end
    clr = 1'b1;
    wait_clks(1);
    clr = 1'b0;
    total++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h47F3) begin
      bad++;
      $display("FAIL cmd_clear rdy=%b cmd=%h exp 0,47F3", cmd_rdy, cmd);
    end
    clr = 1'b1;
    wait_clks(1);
    clr = 1'b0;
    wait_clks(2);
    total++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h47F3) begin
      bad++;
      $display("FAIL clr_idle rdy=%b cmd=%h exp 0,47F3", cmd_rdy, cmd);
    end
  endtask

  task automatic test_random_cmds();
    logic [7:0] h, l;
    for (int n = 0; n < 4; n++) begin
      h = 8'($urandom);
      l = 8'($urandom);
      uart_send(h, 1);
      uart_send(l, 1);
      total++;
      if (cmd !== m_cmd || cmd_rdy !== 1'b1) begin
        bad++;
        $display("FAIL rand_cmd%0d cmd=%h rdy=%b exp %h,1", n, cmd, cmd_rdy, m_cmd);
      end
      clr = 1'b1;
      wait_clks(1);
      clr = 1'b0;
    end
  endtask

  task automatic test_tx();
    tx_frame_check(8'hA5, 1);
    wait_clks(5);
    tx_frame_check(8'($urandom), 0);
    wait_clks(3);
    tx_frame_check(8'($urandom), 1);
  endtask

  task automatic test_framing();
    uart_send(8'h12, 0);
    wait_clks(10);
    uart_send(8'h34, 1);
    uart_send(8'h56, 1);
    total++;
    if (cmd !== 16'h3456 || cmd_rdy !== 1'b1 || m_cmd !== 16'h3456) begin
      bad++;
      $display("FAIL framing cmd=%h rdy=%b exp 3456,1", cmd, cmd_rdy);
    end
    clr = 1'b1;
    wait_clks(1);
    clr = 1'b0;
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    wait_clks(B / 4);
    rx = 1'b1;
    wait_clks(2 * B);
    total++;
    if (cmd_rdy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_rdy got=%b exp 0", cmd_rdy);
    end
    uart_send(8'hAB, 1);
    uart_send(8'hCD, 1);
    total++;
    if (cmd !== 16'hABCD || cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL glitch cmd=%h rdy=%b exp ABCD,1", cmd, cmd_rdy);
    end
    clr = 1'b1;
    wait_clks(1);
    clr = 1'b0;
  endtask

  task automatic test_overwrite();
    int f0;
    bit seen_low, done;
    uart_send(8'h11, 1);
    uart_send(8'h11, 1);
    f0 = falls;
    uart_send(8'h33, 1);
    uart_send(8'h33, 1);
    total++;
    if (cmd !== 16'h3333 || cmd_rdy !== 1'b1 || falls != f0) begin
      bad++;
      $display("FAIL overwrite cmd=%h rdy=%b drops=%0d exp 3333,1,0", cmd, cmd_rdy, falls - f0);
    end
    uart_send(8'h22, 1);
    clr = 1'b1;
    seen_low = 0;
    done = 0;
    fork
      uart_send(8'h22, 1);
      begin
        for (int i = 0; i < 12 * B && !done; i++) begin
          wait_clks(1);
          if (!cmd_rdy) seen_low = 1;
          else if (seen_low) begin
            clr = 1'b0;
            done = 1;
          end
        end
      end
    join
    clr = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL clr_vs_complete cmd_rdy never re-set while clr held, got rdy=%b exp 1", cmd_rdy);
    end
    total++;
    if (cmd !== 16'h2222 || cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL clr_vs_complete_val cmd=%h rdy=%b exp 2222,1", cmd, cmd_rdy);
    end
    clr = 1'b1;
    wait_clks(1);
    clr = 1'b0;
  endtask

  task automatic test_full_duplex();
    logic [7:0] h, l, r;
    h = 8'($urandom);
    l = 8'($urandom);
    r = 8'($urandom);
    fork
      tx_frame_check(r, 0);
      begin
        wait_clks(7);
        uart_send(h, 1);
        uart_send(l, 1);
      end
    join
    total++;
    if (cmd !== m_cmd || cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL duplex cmd=%h rdy=%b exp %h,1", cmd, cmd_rdy, m_cmd);
    end
  endtask

  task automatic test_reset_mid();
    resp = 8'h00;
    send_resp = 1'b1;
    wait_clks(1);
    send_resp = 1'b0;
    wait_clks(3 * B + 5);
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || cmd_rdy !== 1'b0 || cmd !== 16'h0 || resp_sent !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid tx=%b busy=%b rdy=%b cmd=%h sent=%b exp 1,0,0,0000,0",
               tx, tx_busy, cmd_rdy, cmd, resp_sent);
    end
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(3);
    uart_send(8'h5A, 1);
    uart_send(8'hC3, 1);
    total++;
    if (cmd !== 16'h5AC3 || cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL post_reset cmd=%h rdy=%b exp 5AC3,1", cmd, cmd_rdy);
    end
    clr = 1'b1;
    wait_clks(1);
    clr = 1'b0;
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    int p0;
    p0 = tmo_pulses;
    uart_send(8'h47, 1);
    wait_clks(6000);
    m_have_high = 0;
    uart_send(8'h10, 1);
    uart_send(8'h00, 1);
    total++;
    if (tmo_pulses - p0 != 1) begin
      bad++;
      $display("FAIL timeout_pulses got=%0d exp 1", tmo_pulses - p0);
    end
    total++;
    if (cmd !== 16'h1000 || cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_cmd cmd=%h rdy=%b exp 1000,1", cmd, cmd_rdy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cmd();
    test_random_cmds();
    test_tx();
    test_framing();
    test_glitch();
    test_overwrite();
    test_full_duplex();
    test_reset_mid();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
